// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity selectors,
// frame bit levels and the default data width.
package uart_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b011,
      PARITY = 3'b010,
      STOP   = 3'b110
   } uart_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator: maps (data, parity type) to the parity bit.
// Even parity makes the total count of ones even, odd makes it odd.
module uart_tx_parity
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_typ_i,
   output logic                  par_o
);

   // Select even (XOR reduction) or odd (XNOR reduction) parity
   always_comb begin
      par_o = ^data_i;
      if (par_typ_i == PAR_ODD) begin
         par_o = ~^data_i;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one clock per bit. Frame: start bit, DATA_WIDTH data bits
// LSB first, optional parity bit, one stop bit. Outputs are registered: the
// next-state logic also computes the line level for the next state, so
// tx_out/busy change on the same edge as the state.
// Handshake: a request (data_valid=1) is accepted on a rising edge only while
// busy=0; requests seen while busy=1 are dropped, nothing is queued.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy,
   output logic [2:0]            state_dbg
);

   localparam int            CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   uart_state_e           state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  par_bit;

   // Parity is always derived from the latched frame, never the live inputs
   uart_tx_parity #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data_i    (data_q),
      .par_typ_i (par_typ_q),
      .par_o     (par_bit)
   );

   // Next state plus the registered line level/busy for that next state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      tx_d      = STOP_BIT;
      busy_d    = 1'b1;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (data_valid) begin
               data_d    = p_data;
               par_en_d  = par_en;
               par_typ_d = par_typ;
               state_d   = START;
               tx_d      = START_BIT;
               busy_d    = 1'b1;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
            tx_d    = data_q[0];
         end
         DATA: begin
            if (cnt_q == LAST_BIT) begin
               if (par_en_q) begin
                  state_d = PARITY;
                  tx_d    = par_bit;
               end else begin
                  state_d = STOP;
                  tx_d    = STOP_BIT;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               tx_d  = data_q[cnt_d];
            end
         end
         PARITY: begin
            state_d = STOP;
            tx_d    = STOP_BIT;
         end
         STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, frame latch and output registers; reset forces the line idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         tx_q      <= STOP_BIT;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign tx_out    = tx_q;
   assign busy      = busy_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx (DATA_WIDTH=8). Expected line contents come from a
// frame model that lists the bits a frame must carry.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       tx_out;
   logic       busy;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_err    = 0;

   logic [0:0] exp_q[$];
   logic [0:0] got_q[$];

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       pt;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   vec_t vecs[6];

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .tx_out     (tx_out),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Frame model: start 0, eight data bits LSB first, parity if enabled, stop 1
   task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
      int ones;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      if (pe) begin
         ones = $countones(d);
         if (pt == 1'b0) exp_q.push_back(1'((ones % 2)));
         else            exp_q.push_back(1'((1 - ones % 2)));
      end
      exp_q.push_back(1'b1);
   endtask

   // Driver + scoreboard for one frame. Called at a falling edge; returns at
   // the falling edge where busy has dropped. Optional mid-frame disturbance.
   task automatic send_and_check(input logic [7:0] d, input logic pe, input logic pt,
                                 input bit disturb, input string name);
      int n;
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      build_frame(d, pe, pt);
      got_q.delete();
      n = 0;
      while (busy === 1'b1 && n < 16) begin
         got_q.push_back(tx_out);
         if (disturb && n == 3) begin
            p_data     = ~d;
            par_typ    = ~pt;
            par_en     = ~pe;
            data_valid = 1'b1;
         end
         if (disturb && n == 4) data_valid = 1'b0;
         n++;
         @(negedge clk);
      end
      check({name, "_len"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_bit%0d", name, i), got_q[i], exp_q[i]);
      end
      check({name, "_busy_end"}, busy, 1'b0);
      check({name, "_idle_line"}, tx_out, 1'b1);
   endtask

   initial begin
      int busy_cnt;
      logic [0:0] b2b_q[$];
      logic [0:0] b2b_busy[$];
      logic [7:0] rd;
      logic rpe, rpt;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
      vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 11};
      vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 11};
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};

      // reset block
      rst        = 1'b0;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx", tx_out, 1'b1);
         check("rst_busy", busy, 1'b0);
      end
      check("rst_state", state_dbg, 3'b000);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("idle_tx", tx_out, 1'b1);
         check("idle_busy", busy, 1'b0);
      end

      // explicit 0xA5 no-parity line sequence
      send_and_check(8'hA5, 1'b0, 1'b0, 1'b0, "a5");
      check("a5_seq", {got_q[0], got_q[1], got_q[2], got_q[3], got_q[4],
                       got_q[5], got_q[6], got_q[7], got_q[8], got_q[9]},
            10'b0101001011);

      // table-driven vectors
      foreach (vecs[k]) begin
         @(negedge clk);
         send_and_check(vecs[k].data, vecs[k].pe, vecs[k].pt, 1'b0, $sformatf("vec%0d", k));
         check($sformatf("vec%0d_tlen", k), got_q.size(), vecs[k].exp_len);
         if (vecs[k].pe)
            check($sformatf("vec%0d_par", k), (got_q.size() > 9) ? got_q[9] : 1'bx,
                  vecs[k].exp_par);
      end

      // back-to-back with data_valid held: 0x55 then 0xFF, even parity
      @(negedge clk);
      build_frame(8'h55, 1'b1, 1'b0);
      b2b_q = exp_q;
      b2b_q.push_back(1'b1);
      build_frame(8'hFF, 1'b1, 1'b0);
      foreach (exp_q[i]) b2b_q.push_back(exp_q[i]);
      b2b_busy.delete();
      for (int i = 0; i < 23; i++) b2b_busy.push_back((i == 11) ? 1'b0 : 1'b1);
      p_data     = 8'h55;
      par_en     = 1'b1;
      par_typ    = 1'b0;
      data_valid = 1'b1;
      @(negedge clk);
      p_data = 8'hFF;
      for (int i = 0; i < 23; i++) begin
         check($sformatf("b2b_tx%0d", i), tx_out, b2b_q[i]);
         check($sformatf("b2b_busy%0d", i), busy, b2b_busy[i]);
         if (i == 12) data_valid = 1'b0;
         @(negedge clk);
      end
      check("b2b_end_busy", busy, 1'b0);

      // mid-frame interference: frame unchanged, nothing extra sent
      @(negedge clk);
      send_and_check(8'h96, 1'b1, 1'b0, 1'b1, "intf");
      busy_cnt = 0;
      repeat (15) begin
         if (busy !== 1'b0 || tx_out !== 1'b1) busy_cnt++;
         @(negedge clk);
      end
      check("intf_no_extra", busy_cnt, 0);

      // randomized frames against the model
      for (int r = 0; r < 20; r++) begin
         rd  = 8'($urandom_range(0, 255));
         rpe = 1'($urandom_range(0, 1));
         rpt = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_and_check(rd, rpe, rpt, 1'b0, $sformatf("rnd%0d", r));
      end

      // asynchronous reset during data bit 4 of 0xE0 (bit 4 is 0)
      @(negedge clk);
      p_data     = 8'hE0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_tx", tx_out, 1'b0);
      check("pre_rst_busy", busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_tx", tx_out, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_state", state_dbg, 3'b000);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_tx", tx_out, 1'b1);
         check("post_rst_busy", busy, 1'b0);
      end
      send_and_check(8'h3C, 1'b0, 1'b0, 1'b0, "after_rst");

      // final report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
